// File: rtl/estagio_escrita_ula.sv
// Writeback stage after the ULA: 2-entry commit buffer draining into the register bank and flags.
// Read ports bypass from buffered entries so the ULA always sees the newest value.
module estagio_escrita_ula #(
  parameter int unsigned bits_palavra = 16,
  parameter int unsigned num_regs     = 8,
  parameter int unsigned bits_end     = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valido,
  output logic                    in_pronto,
  input  logic [bits_palavra-1:0] in_resultado,
  input  logic [bits_end-1:0]     in_destino,
  input  logic                    in_escreve,
  input  logic [1:0]              in_classe,
  input  logic                    in_Z,
  input  logic                    in_C,
  input  logic                    in_S,
  input  logic                    in_O,
  input  logic                    comita,
  input  logic [bits_end-1:0]     end_a,
  input  logic [bits_end-1:0]     end_b,
  output logic [bits_palavra-1:0] operandoA,
  output logic [bits_palavra-1:0] operandoB,
  output logic                    Z,
  output logic                    C,
  output logic                    S,
  output logic                    O,
  output logic                    flags_pendentes,
  output logic [1:0]              ocupacao
);

  typedef struct packed {
    logic [bits_palavra-1:0] resultado;
    logic [bits_end-1:0]     destino;
    logic                    escreve;
    logic [1:0]              classe;
    logic                    z;
    logic                    c;
    logic                    s;
    logic                    o;
  } entrada_t;

  entrada_t                fila_q [2];
  logic                    cab_q;
  logic                    cauda_q;
  logic [1:0]              ocup_q;
  logic [bits_palavra-1:0] banco_q [num_regs];
  logic                    z_q, c_q, s_q, o_q;

  entrada_t nova;
  entrada_t velho;
  entrada_t jovem;
  logic     aceita;
  logic     drena;

  assign nova = '{resultado: in_resultado, destino: in_destino, escreve: in_escreve,
                  classe: in_classe, z: in_Z, c: in_C, s: in_S, o: in_O};

  assign in_pronto = (ocup_q < 2'd2);
  assign aceita    = in_valido & in_pronto;
  assign drena     = comita & (ocup_q != 2'd0);
  assign velho     = fila_q[cab_q];
  // The youngest entry always sits just behind the tail pointer.
  assign jovem     = fila_q[~cauda_q];

  always_ff @(posedge clock) begin
    if (aceita) begin
      fila_q[cauda_q] <= nova;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cab_q   <= 1'b0;
      cauda_q <= 1'b0;
      ocup_q  <= 2'd0;
    end else begin
      if (aceita) begin
        cauda_q <= ~cauda_q;
      end
      if (drena) begin
        cab_q <= ~cab_q;
      end
      if (aceita && !drena) begin
        ocup_q <= ocup_q + 2'd1;
      end else if (drena && !aceita) begin
        ocup_q <= ocup_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(num_regs); i++) begin
        banco_q[i] <= '0;
      end
    end else if (drena && velho.escreve) begin
      banco_q[velho.destino] <= velho.resultado;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
      s_q <= 1'b0;
      o_q <= 1'b0;
    end else if (drena) begin
      case (velho.classe)
        2'b11: begin
          z_q <= velho.z;
          c_q <= velho.c;
          s_q <= velho.s;
          o_q <= velho.o;
        end
        2'b10: begin
          z_q <= velho.z;
          c_q <= velho.c;
          s_q <= velho.s;
        end
        2'b01: begin
          z_q <= velho.z;
          s_q <= velho.s;
        end
        default: ;
      endcase
    end
  end

  // Older match first, younger match overrides it.
  always_comb begin
    operandoA = banco_q[end_a];
    operandoB = banco_q[end_b];
    if (ocup_q == 2'd2 && velho.escreve && velho.destino == end_a) begin
      operandoA = velho.resultado;
    end
    if (ocup_q == 2'd2 && velho.escreve && velho.destino == end_b) begin
      operandoB = velho.resultado;
    end
    if (ocup_q != 2'd0 && jovem.escreve && jovem.destino == end_a) begin
      operandoA = jovem.resultado;
    end
    if (ocup_q != 2'd0 && jovem.escreve && jovem.destino == end_b) begin
      operandoB = jovem.resultado;
    end
  end

  assign flags_pendentes = (ocup_q != 2'd0 && jovem.classe != 2'b00) ||
                           (ocup_q == 2'd2 && velho.classe != 2'b00);

  assign ocupacao = ocup_q;
  assign Z        = z_q;
  assign C        = c_q;
  assign S        = s_q;
  assign O        = o_q;

endmodule

// File: tb/tb_estagio_escrita_ula.sv
// Bench for estagio_escrita_ula: hand-written vector table, mid-cycle reset, then
// random traffic against a queue-based reference model.
module tb_estagio_escrita_ula;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valido, in_pronto;
  logic [15:0] in_resultado;
  logic [2:0]  in_destino;
  logic        in_escreve;
  logic [1:0]  in_classe;
  logic        in_Z, in_C, in_S, in_O;
  logic        comita;
  logic [2:0]  end_a, end_b;
  logic [15:0] operandoA, operandoB;
  logic        Z, C, S, O;
  logic        flags_pendentes;
  logic [1:0]  ocupacao;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  estagio_escrita_ula #(.bits_palavra(16), .num_regs(8), .bits_end(3)) dut (
    .clock(clock), .reset_n(reset_n), .in_valido(in_valido), .in_pronto(in_pronto),
    .in_resultado(in_resultado), .in_destino(in_destino), .in_escreve(in_escreve),
    .in_classe(in_classe), .in_Z(in_Z), .in_C(in_C), .in_S(in_S), .in_O(in_O),
    .comita(comita), .end_a(end_a), .end_b(end_b), .operandoA(operandoA),
    .operandoB(operandoB), .Z(Z), .C(C), .S(S), .O(O),
    .flags_pendentes(flags_pendentes), .ocupacao(ocupacao)
  );

  // Reference model: pending entries in arrival order, bank array, flags {Z,C,S,O}.
  typedef struct {
    logic [15:0] res;
    logic [2:0]  dst;
    logic        wr;
    logic [1:0]  cls;
    logic [3:0]  f;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mbank[8];
  logic [3:0]  mflags;

  typedef struct {
    logic v; logic [15:0] res; logic [2:0] dst; logic wr; logic [1:0] cls; logic [3:0] f;
    logic com; logic [2:0] ea; logic [2:0] eb;
    logic [1:0] e_ocup; logic e_pronto; logic e_pend; logic [15:0] e_opa; logic [15:0] e_opb;
    logic [3:0] e_f;
  } vec_t;

  vec_t tab[19];

  function automatic vec_t mk(input logic v, input logic [15:0] res, input logic [2:0] dst,
                              input logic wr, input logic [1:0] cls, input logic [3:0] f,
                              input logic com, input logic [2:0] ea, input logic [2:0] eb,
                              input logic [1:0] ocup, input logic pronto, input logic pend,
                              input logic [15:0] opa, input logic [15:0] opb,
                              input logic [3:0] ef);
    vec_t r;
    r = '{v, res, dst, wr, cls, f, com, ea, eb, ocup, pronto, pend, opa, opb, ef};
    return r;
  endfunction

  function automatic logic [3:0] mascara(input logic [1:0] cls);
    case (cls)
      2'b11:   return 4'b1111;
      2'b10:   return 4'b1110;
      2'b01:   return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [15:0] mread(input logic [2:0] a);
    logic [15:0] r;
    r = mbank[a];
    foreach (mq[i]) if (mq[i].wr && mq[i].dst == a) r = mq[i].res;
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    foreach (mbank[i]) mbank[i] = 16'h0;
    mflags = 4'b0000;
  endtask

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle 1 ns past the edge.
  task automatic apply(input logic v, input logic [15:0] res, input logic [2:0] dst,
                       input logic wr, input logic [1:0] cls, input logic [3:0] f,
                       input logic com, input logic [2:0] ea, input logic [2:0] eb);
    bit   pop, push;
    ent_t e;
    in_valido = v; in_resultado = res; in_destino = dst; in_escreve = wr; in_classe = cls;
    {in_Z, in_C, in_S, in_O} = f;
    comita = com; end_a = ea; end_b = eb;
    @(posedge clock);
    pop  = com && mq.size() > 0;
    push = v && mq.size() < 2;
    if (pop) begin
      e = mq.pop_front();
      if (e.wr) mbank[e.dst] = e.res;
      mflags = (mflags & ~mascara(e.cls)) | (e.f & mascara(e.cls));
    end
    if (push) mq.push_back('{res, dst, wr, cls, f});
    #1;
  endtask

  task automatic chk_model(input string tag);
    logic pend;
    pend = 1'b0;
    foreach (mq[i]) if (mq[i].cls != 2'b00) pend = 1'b1;
    chk({tag, " ocupacao"}, 32'(ocupacao), 32'(mq.size()));
    chk({tag, " in_pronto"}, 32'(in_pronto), 32'(mq.size() < 2));
    chk({tag, " flags_pendentes"}, 32'(flags_pendentes), 32'(pend));
    chk({tag, " operandoA"}, 32'(operandoA), 32'(mread(end_a)));
    chk({tag, " operandoB"}, 32'(operandoB), 32'(mread(end_b)));
    chk({tag, " flags"}, 32'({Z, C, S, O}), 32'(mflags));
  endtask

  initial begin
    tab[0]  = mk(1, 16'h1234, 3, 1, 2'b11, 4'b0101, 1, 3, 3, 1, 1, 1, 16'h1234, 16'h1234, 4'b0000);
    tab[1]  = mk(0, 16'h0000, 0, 0, 2'b00, 4'b0000, 1, 3, 0, 0, 1, 0, 16'h1234, 16'h0000, 4'b0101);
    tab[2]  = mk(1, 16'h00A1, 1, 1, 2'b00, 4'b0000, 0, 1, 2, 1, 1, 0, 16'h00A1, 16'h0000, 4'b0101);
    tab[3]  = mk(1, 16'h00B2, 2, 1, 2'b00, 4'b0000, 0, 1, 2, 2, 0, 0, 16'h00A1, 16'h00B2, 4'b0101);
    tab[4]  = mk(1, 16'h00C4, 4, 1, 2'b00, 4'b0000, 0, 4, 2, 2, 0, 0, 16'h0000, 16'h00B2, 4'b0101);
    tab[5]  = mk(1, 16'h00C4, 4, 1, 2'b00, 4'b0000, 1, 4, 1, 1, 1, 0, 16'h0000, 16'h00A1, 4'b0101);
    tab[6]  = mk(1, 16'h00C4, 4, 1, 2'b00, 4'b0000, 1, 4, 2, 1, 1, 0, 16'h00C4, 16'h00B2, 4'b0101);
    tab[7]  = mk(0, 16'h0000, 0, 0, 2'b00, 4'b0000, 1, 4, 1, 0, 1, 0, 16'h00C4, 16'h00A1, 4'b0101);
    tab[8]  = mk(1, 16'h0001, 5, 1, 2'b00, 4'b0000, 0, 5, 5, 1, 1, 0, 16'h0001, 16'h0001, 4'b0101);
    tab[9]  = mk(1, 16'h0002, 5, 1, 2'b00, 4'b0000, 0, 0, 5, 2, 0, 0, 16'h0000, 16'h0002, 4'b0101);
    tab[10] = mk(0, 16'h0000, 0, 0, 2'b00, 4'b0000, 1, 5, 5, 1, 1, 0, 16'h0002, 16'h0002, 4'b0101);
    tab[11] = mk(0, 16'h0000, 0, 0, 2'b00, 4'b0000, 1, 5, 5, 0, 1, 0, 16'h0002, 16'h0002, 4'b0101);
    tab[12] = mk(1, 16'h0000, 0, 0, 2'b11, 4'b1111, 1, 0, 0, 1, 1, 1, 16'h0000, 16'h0000, 4'b0101);
    tab[13] = mk(1, 16'h0000, 0, 0, 2'b01, 4'b0000, 1, 0, 0, 1, 1, 1, 16'h0000, 16'h0000, 4'b1111);
    tab[14] = mk(1, 16'h0000, 0, 0, 2'b10, 4'b0000, 1, 0, 0, 1, 1, 1, 16'h0000, 16'h0000, 4'b0101);
    tab[15] = mk(1, 16'h0000, 0, 0, 2'b00, 4'b1111, 1, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 4'b0001);
    tab[16] = mk(0, 16'h0000, 0, 0, 2'b00, 4'b0000, 1, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 4'b0001);
    tab[17] = mk(1, 16'hFFFF, 3, 0, 2'b11, 4'b1010, 0, 3, 3, 1, 1, 1, 16'h1234, 16'h1234, 4'b0001);
    tab[18] = mk(0, 16'h0000, 0, 0, 2'b00, 4'b0000, 1, 3, 3, 0, 1, 0, 16'h1234, 16'h1234, 4'b1010);

    reset_n = 1'b0;
    in_valido = 1'b0; in_resultado = '0; in_destino = '0; in_escreve = 1'b0; in_classe = '0;
    {in_Z, in_C, in_S, in_O} = 4'b0000;
    comita = 1'b0; end_a = 3'd0; end_b = 3'd0;
    model_reset();
    #2;
    chk("reset ocupacao", 32'(ocupacao), 32'd0);
    chk("reset in_pronto", 32'(in_pronto), 32'd1);
    chk("reset flags_pendentes", 32'(flags_pendentes), 32'd0);
    chk("reset flags", 32'({Z, C, S, O}), 32'd0);
    chk("reset operandoA", 32'(operandoA), 32'd0);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      apply(tab[i].v, tab[i].res, tab[i].dst, tab[i].wr, tab[i].cls, tab[i].f,
            tab[i].com, tab[i].ea, tab[i].eb);
      chk($sformatf("vec%0d ocupacao", i), 32'(ocupacao), 32'(tab[i].e_ocup));
      chk($sformatf("vec%0d in_pronto", i), 32'(in_pronto), 32'(tab[i].e_pronto));
      chk($sformatf("vec%0d flags_pendentes", i), 32'(flags_pendentes), 32'(tab[i].e_pend));
      chk($sformatf("vec%0d operandoA", i), 32'(operandoA), 32'(tab[i].e_opa));
      chk($sformatf("vec%0d operandoB", i), 32'(operandoB), 32'(tab[i].e_opb));
      chk($sformatf("vec%0d flags", i), 32'({Z, C, S, O}), 32'(tab[i].e_f));
    end

    // Fill the buffer, then reset between edges: pending writes must vanish.
    apply(1, 16'h6666, 6, 1, 2'b11, 4'b1111, 0, 6, 7);
    apply(1, 16'h7777, 7, 1, 2'b11, 4'b1111, 0, 6, 7);
    chk("prefill ocupacao", 32'(ocupacao), 32'd2);
    in_valido = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("midreset ocupacao", 32'(ocupacao), 32'd0);
    chk("midreset in_pronto", 32'(in_pronto), 32'd1);
    chk("midreset flags_pendentes", 32'(flags_pendentes), 32'd0);
    chk("midreset flags", 32'({Z, C, S, O}), 32'd0);
    for (int a = 0; a < 8; a++) begin
      end_a = 3'(a); end_b = 3'(7 - a);
      #1;
      chk($sformatf("midreset bank%0d", a), 32'(operandoA), 32'd0);
      chk($sformatf("midreset bank%0d", 7 - a), 32'(operandoB), 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(0, 16'h0000, 0, 0, 2'b00, 4'b0000, 1, 6, 7);
      chk_model($sformatf("postreset%0d", k));
    end

    for (int k = 0; k < 600; k++) begin
      apply($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      chk_model($sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/estagio_escrita_ula.md
Name: estagio_escrita_ula

Overview:
- Writeback stage directly downstream of the ULA.
- Accepts the ULA result, its four flags and the flag-update class through a valid/ready handshake, and holds them in a 2-entry commit buffer.
- Drains entries into an 8-word register bank and a committed flag register (Z, C, S, O).
- Provides two combinational operand read ports, with bypass from pending entries, that feed operandoA/operandoB of the ULA.

Parameters:
- bits_palavra, 16, word width; matches the ULA operand/result width.
- num_regs, 8, number of registers in the bank.
- bits_end, 3, register address width; must equal log2(num_regs).

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valido  input  1  upstream entry valid.
- in_pronto  output  1  stage can accept an entry.
- in_resultado  input  bits_palavra  ULA resultadoOp.
- in_destino  input  bits_end  destination register index.
- in_escreve  input  1  1 = write in_resultado to the bank; 0 = flags only.
- in_classe  input  2  flag class: 11 = Z,C,S,O; 10 = Z,C,S; 01 = Z,S; 00 = none.
- in_Z, in_C, in_S, in_O  input  1 each  ULA flags.
- comita  input  1  commit enable from control; 0 stalls the drain.
- end_a, end_b  input  bits_end  read addresses.
- operandoA, operandoB  output  bits_palavra  read data (combinational).
- Z, C, S, O  output  1 each  committed flags.
- flags_pendentes  output  1  some buffered entry has in_classe != 00.
- ocupacao  output  2  buffer count (0..2).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset assertion (any time, including mid-operation):
  - All bank words = 0; Z = C = S = O = 0.
  - Buffer emptied; pending entries are discarded without commit.
  - ocupacao = 0, in_pronto = 1, flags_pendentes = 0.
- Buffer: 2-entry FIFO (head/tail pointers plus count); each entry stores {resultado, destino, escreve, classe, Z, C, S, O}.
- in_pronto = (ocupacao < 2). It is registered-state derived and has no combinational dependency on in_valido or comita.
- Push: on a rising edge with in_valido & in_pronto, the entry is written at the tail.
- Pop: on a rising edge with comita & (ocupacao > 0), the head entry commits and is removed.
  - Bank write when escreve = 1: bank[destino] <= resultado. All registers, including index 0, are writable.
  - Flag update by class:
    - 11: Z, C, S and O all load.
    - 10: Z, C and S load; O holds.
    - 01: Z and S load; C and O hold.
    - 00: all flags hold.
- Simultaneous push and pop in one edge: both happen and ocupacao is unchanged. This is legal at ocupacao = 1. At ocupacao = 2 no push occurs because in_pronto = 0.
- Latency:
  - An entry accepted at edge N is committed no earlier than edge N+1 (with comita = 1 at N+1).
  - A committed value is visible on Z/C/S/O and in the bank from edge N+1 onward.
- Read ports: operandoX = youngest buffered entry with escreve = 1 and destino = end_x; otherwise bank[end_x].
  - The incoming, not-yet-accepted entry is never bypassed.
  - The youngest entry wins when both buffered entries match.
  - An entry stays bypassable until the same edge that writes it into the bank, so the visible value is seamless.
- flags_pendentes: OR over valid buffer entries of (classe != 00). It is combinational from registered state.
- ocupacao: the registered count.
- Pointers wrap modulo 2.
- Signals sampled while in_valido = 0 are ignored. Inputs are X-tolerant when in_valido = 0.

Test Plan:
- Reset, then in_valido = 1 with resultado = 0x1234, destino = 3, escreve = 1, classe = 11, Z/C/S/O = 0/1/0/1, comita = 1 → after edge 1, ocupacao = 1 and operandoA(end_a = 3) = 0x1234 via bypass; after edge 2, bank[3] = 0x1234, C = 1, O = 1, ocupacao = 0.
- comita = 0, push 3 entries on consecutive cycles → ocupacao = 2 and in_pronto = 0 after the 2nd accept; the 3rd is held until comita = 1. Then one commit per edge in order, and the bank matches the push order.
- Two buffered entries to destino = 5 (0x0001 then 0x0002), comita = 0 → operandoB(end_b = 5) = 0x0002. Draining the first gives bank[5] = 0x0001 with the read still 0x0002; draining the second gives bank[5] = 0x0002.
- Flag classes:
  - Preset flags to 1/1/1/1, commit class 01 with Z/C/S/O = 0/0/0/0 → Z = 0, S = 0, C = 1, O = 1.
  - Then commit class 10 with Z/C/S/O = 0/0/0/0 → C = 0, O = 1.
  - Then commit class 00 → no change.
- Entry with escreve = 0, classe = 11 → no bank change while flags update. While it is buffered, flags_pendentes = 1; it returns to 0 after the drain.
- Fill the buffer to 2, deassert reset_n between clock edges → ocupacao = 0, in_pronto = 1 and all bank words = 0 immediately. After release the discarded entries never commit.
